// File: rtl/linear_pkg.sv
// ============================================================================
// Module  : linear_pkg
// Brief   : Shared element widths, element typedefs and index helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package linear_pkg;

    localparam int c_DEFAULT_PRECISION      = 8;
    localparam int c_DEFAULT_BIAS_PRECISION = 32;

    typedef logic [c_DEFAULT_PRECISION-1:0]      q_elem_t;
    typedef logic [c_DEFAULT_BIAS_PRECISION-1:0] long_elem_t;

    // Index counters need at least one bit even when only one value exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vector_fifo.sv
// ============================================================================
// Module  : vector_fifo
// Brief   : Vector-wide FIFO with occupancy count; head vector read directly.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_fifo #(
    parameter int WIDTH        = 8,
    parameter int NUM_FEATURES = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [WIDTH-1:0]              i_wr_vec   [NUM_FEATURES],
    input  logic                          i_rd_en,
    output logic [WIDTH-1:0]              o_head_vec [NUM_FEATURES],
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int              c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0]   r_mem [FIFO_DEPTH][NUM_FEATURES];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_wr;
    logic w_rd;

    assign w_wr = i_wr_en & (r_count != c_FULL);
    assign w_rd = i_rd_en & (r_count != '0);

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                r_mem[r_wr_ptr][f] <= i_wr_vec[f];
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
            o_head_vec[f] = r_mem[r_rd_ptr][f];
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/output_serializer.sv
// ============================================================================
// Module  : output_serializer
// Brief   : Buffers result vectors and streams them one element per handshake
//           with frame (row) tracking. Macro OUTPUT_SERIALIZER_LONG_OUT_EN adds
//           the long-value path (in_long / m_long).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module output_serializer
    import linear_pkg::*;
#(
    parameter int PRECISION      = c_DEFAULT_PRECISION,
    parameter int BIAS_PRECISION = c_DEFAULT_BIAS_PRECISION,
    parameter int NUM_FEATURES   = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int ROWS           = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [PRECISION-1:0]          in_data [NUM_FEATURES],
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
    input  logic [BIAS_PRECISION-1:0]     in_long [NUM_FEATURES],
`endif
    output logic                          in_ready,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [PRECISION-1:0]          m_data,
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
    output logic [BIAS_PRECISION-1:0]     m_long,
`endif
    output logic                          m_last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
    localparam bit c_LONG_EN = 1'b1;
`else
    localparam bit c_LONG_EN = 1'b0;
`endif

    localparam int c_ELEM_W = PRECISION + (c_LONG_EN ? BIAS_PRECISION : 0);
    localparam int c_EIDX_W = idx_width(NUM_FEATURES);
    localparam int c_ROW_W  = idx_width(ROWS);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_EIDX_W-1:0] c_LAST_ELEM = c_EIDX_W'(NUM_FEATURES - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(ROWS - 1);

    logic [c_ELEM_W-1:0] w_wr_vec   [NUM_FEATURES];
    logic [c_ELEM_W-1:0] w_head_vec [NUM_FEATURES];
    logic [c_ELEM_W-1:0] w_head_elem;

    logic [c_EIDX_W-1:0] r_elem;
    logic [c_ROW_W-1:0]  r_row;
    logic                r_overflow;

    logic w_full;
    logic w_wr_en;
    logic w_valid;
    logic w_hs;
    logic w_elem_end;
    logic w_pop;

    // Each slot element carries the long value above the quantised value.
    for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_pack
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
        assign w_wr_vec[f] = {in_long[f], in_data[f]};
`else
        assign w_wr_vec[f] = in_data[f];
`endif
    end

    assign w_full     = (count == c_CNT_W'(FIFO_DEPTH));
    assign w_wr_en    = in_valid & ~w_full & ~rst;
    assign w_valid    = (count != '0) & ~rst;
    assign w_hs       = w_valid & m_ready;
    assign w_elem_end = (r_elem == c_LAST_ELEM);
    assign w_pop      = w_hs & w_elem_end;

    vector_fifo #(
        .WIDTH        (c_ELEM_W),
        .NUM_FEATURES (NUM_FEATURES),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_vector_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_vec   (w_wr_vec),
        .i_rd_en    (w_pop),
        .o_head_vec (w_head_vec),
        .o_count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_elem     <= '0;
            r_row      <= '0;
            r_overflow <= 1'b0;
        end else begin
            // A full FIFO drops the vector even if this cycle also pops.
            if (in_valid && w_full) r_overflow <= 1'b1;
            if (w_hs) begin
                if (w_elem_end) begin
                    r_elem <= '0;
                    r_row  <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
                end else begin
                    r_elem <= r_elem + 1'b1;
                end
            end
        end
    end

    assign w_head_elem = w_head_vec[r_elem];

    assign m_valid  = w_valid;
    assign m_data   = w_valid ? w_head_elem[PRECISION-1:0] : '0;
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
    assign m_long   = w_valid ? w_head_elem[c_ELEM_W-1:PRECISION] : '0;
`endif
    assign m_last   = w_valid & w_elem_end & (r_row == c_LAST_ROW);
    assign in_ready = rst | ~w_full;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_output_serializer.sv
// ============================================================================
// Module  : tb_output_serializer
// Brief   : Directed and randomised-ready bench for output_serializer with a
//           scoreboard queue; OUTPUT_SERIALIZER_LONG_OUT_EN enables m_long checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_serializer;
    import linear_pkg::*;

    localparam int NF    = 2;
    localparam int DEPTH = 4;
    localparam int ROWS  = 3;
    localparam int PW    = c_DEFAULT_PRECISION;
    localparam int BW    = c_DEFAULT_BIAS_PRECISION;

    typedef struct {
        logic [PW-1:0] data;
        logic [BW-1:0] lng;
        logic          last;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    q_elem_t                   in_data [NF];
    logic                      in_ready;
    logic                      m_valid;
    logic                      m_ready;
    logic [PW-1:0]             m_data;
    logic                      m_last;
    logic                      overflow;
    logic [$clog2(DEPTH):0]    count;
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
    long_elem_t                in_long [NF];
    logic [BW-1:0]             m_long;
`endif

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   model_row = 0;
    int   n_last    = 0;

    always #5 clk = ~clk;

    output_serializer #(
        .PRECISION      (PW),
        .BIAS_PRECISION (BW),
        .NUM_FEATURES   (NF),
        .FIFO_DEPTH     (DEPTH),
        .ROWS           (ROWS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
        .in_long  (in_long),
        .m_long   (m_long),
`endif
        .in_ready (in_ready),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .overflow (overflow),
        .count    (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector for the coming edge and record its expected elements.
    task automatic drive_vec(input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                             input logic [BW-1:0] l0, input logic [BW-1:0] l1);
        exp_t e;
        in_valid   = 1'b1;
        in_data[0] = d0;
        in_data[1] = d1;
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
        in_long[0] = l0;
        in_long[1] = l1;
`endif
        for (int k = 0; k < NF; k++) begin
            e.data = (k == 0) ? d0 : d1;
            e.lng  = (k == 0) ? l0 : l1;
            e.last = (k == NF - 1) && (model_row == ROWS - 1);
            sb.push_back(e);
        end
        model_row = (model_row == ROWS - 1) ? 0 : model_row + 1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        sb.delete();
        model_row = 0;
        n_last    = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check("drain_remaining", sb.size(), 0);
        @(negedge clk);
        check("idle_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (sb.size() == 0) begin
                check("extra_output", 1, 0);
            end else begin
                check("m_data", m_data, sb[0].data);
                check("m_last", m_last, sb[0].last);
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
                check("m_long", m_long, sb[0].lng);
`endif
                if (m_ready) begin
                    if (m_last) n_last++;
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        rst        = 1'b1;
        in_valid   = 1'b0;
        m_ready    = 1'b0;
        in_data[0] = '0;
        in_data[1] = '0;
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
        in_long[0] = '0;
        in_long[1] = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
        check("rst_m_long", m_long, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single vector: first element one cycle after the write edge.
        m_ready = 1'b1;
        drive_vec(8'h11, 8'h22, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_m_valid", m_valid, 1);
        check("lat_m_data", m_data, 8'h11);
        tick();
        @(negedge clk);
        check("second_elem", m_data, 8'h22);
        tick();
        drain();

        // Fill with consumer stalled, then overflow with a fifth vector.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_vec(8'(8'h30 + 2*i), 8'(8'h31 + 2*i), 32'(i), 32'(i + 100));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_overflow", overflow, 0);
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        in_data[0] = 8'hEE;
        in_data[1] = 8'hEF;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, DEPTH);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        check("ovf_sticky", overflow, 1);

        // Reset after the first element; concurrent write must be ignored.
        drive_vec(8'hA1, 8'hA2, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        rst        = 1'b1;
        sb.delete();
        model_row  = 0;
        n_last     = 0;
        in_valid   = 1'b1;
        in_data[0] = 8'h55;
        in_data[1] = 8'h56;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        drive_vec(8'hB1, 8'hB2, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("restart_elem0", m_data, 8'hB1);
        check("restart_row0", m_last, 0);
        @(posedge clk);
        #1;
        drain();

        // Two frames of ROWS vectors: m_last on elements 6 and 12 only.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 2 * ROWS; i++) begin
            drive_vec(8'(8'h60 + 2*i), 8'(8'h61 + 2*i), 32'h0, 32'h0);
            tick();
            in_valid = 1'b0;
            tick();
        end
        drain();
        check("frame_last_count", n_last, 2);

        // Random consumer stalls with writes whenever space is available.
        do_reset();
        sent = 0;
        for (int c = 0; c < 2000 && sent < 40; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (in_ready) begin
                drive_vec(8'($urandom), 8'($urandom), $urandom, $urandom);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        m_ready  = 1'b1;
        check("rand_sent", sent, 40);
        drain();
        check("rand_overflow", overflow, 0);

`ifdef OUTPUT_SERIALIZER_LONG_OUT_EN
        // Long values travel alongside their quantised elements.
        do_reset();
        m_ready = 1'b1;
        drive_vec(8'h5A, 8'hA5, 32'hDEADBEEF, 32'h1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("long_elem0", m_long, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 SHALL have parameter PRECISION, default 8, meaning width of one quantised output element.
REQ-002 SHALL have parameter BIAS_PRECISION, default 32, meaning width of one long (pre-requant) output element.
REQ-003 SHALL have parameter NUM_FEATURES, default 2, meaning elements per parallel output vector.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning vector slots; power of two, at least 2.
REQ-005 SHALL have parameter ROWS, default 16, meaning vectors per output frame; at least 1.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1, meaning in_data is a valid result vector this cycle.
REQ-009 SHALL have port in_data, input, NUM_FEATURES x PRECISION (unpacked), meaning the quantised output vector.
REQ-010 SHALL have port in_long, input, NUM_FEATURES x BIAS_PRECISION (unpacked), meaning the long output vector; present only with LONG_OUT_EN.
REQ-011 SHALL have port in_ready, output, 1, meaning count != FIFO_DEPTH; advisory, since upstream has no stall.
REQ-012 SHALL have port m_valid, output, 1, meaning m_data holds a valid element.
REQ-013 SHALL have port m_ready, input, 1, meaning the downstream consumer accepts the element.
REQ-014 SHALL have port m_data, output, PRECISION, meaning the current element.
REQ-015 SHALL have port m_long, output, BIAS_PRECISION, meaning the long value of the current element; present only with LONG_OUT_EN.
REQ-016 SHALL have port m_last, output, 1, meaning the final element of the final vector of a frame.
REQ-017 SHALL have port overflow, output, 1, meaning a sticky flag set when a vector was dropped.
REQ-018 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, meaning the number of occupied vector slots.

Function
REQ-019 SHALL write in_data (and in_long) into the tail slot when in_valid=1 and count<FIFO_DEPTH.
REQ-020 SHALL drop the vector and set overflow when in_valid=1 and count==FIFO_DEPTH, even if a pop occurs in the same cycle.
REQ-021 SHALL drive m_valid = (count!=0), m_data = head[elem] and m_long = head_long[elem], where elem is the element index, 0..NUM_FEATURES-1.
REQ-022 SHALL treat a cycle with m_valid=1 and m_ready=1 as a handshake; elem increments, and at elem==NUM_FEATURES-1 the head vector is popped, elem returns to 0 and row increments.
REQ-023 SHALL wrap row from ROWS-1 to 0.
REQ-024 SHALL drive m_last = m_valid & (elem==NUM_FEATURES-1) & (row==ROWS-1).
REQ-025 SHALL hold m_valid, m_data, m_long and m_last stable while m_valid=1 and m_ready=0.
REQ-026 SHALL assert m_valid with in_data[0] in cycle t+1 after a write at edge t into an empty FIFO; no combinational path from in_* to m_*.
REQ-027 SHALL, on a simultaneous write and pop, leave count unchanged and keep data order intact.
REQ-028 SHALL wrap read and write pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, while rst=1, clear count, pointers, elem, row and overflow, with m_valid=0, m_last=0, m_data=0, m_long=0 and in_ready=1; slot contents need not be cleared.
REQ-030 SHALL, when rst is asserted mid-vector or mid-frame, discard partial progress and ignore any concurrent in_valid.

Configuration
REQ-031 SHALL, when macro OUTPUT_SERIALIZER_LONG_OUT_EN is defined, include in_long, m_long and the long storage.
REQ-032 SHALL, when OUTPUT_SERIALIZER_LONG_OUT_EN is undefined, omit those ports and storage, with all other behaviour identical.

Structure
REQ-033 SHALL import PRECISION/BIAS_PRECISION defaults and the element typedefs from the shared linear_pkg package.
REQ-034 SHALL instantiate one sub-module, vector_fifo, that holds the storage and pointers; serialisation and row counting stay in the top module.

Verification
REQ-035 SHALL cover: NUM_FEATURES=2, write {0x11,0x22}, m_ready=1 -> m_data 0x11 in cycle t+1, then 0x22, then m_valid=0.
REQ-036 SHALL cover: fill 4 vectors with m_ready=0 and then write a 5th -> 5th dropped, overflow=1, in_ready=0, and the first 4 vectors output in order.
REQ-037 SHALL cover: ROWS=3, stream 3 vectors -> m_last high only on the 6th element, and high again on the 12th for the next frame.
REQ-038 SHALL cover: random m_ready toggling with continuous in_valid under capacity -> m_data stable while stalled, no loss, no duplication.
REQ-039 SHALL cover: rst pulsed after the 1st element of a vector -> m_valid=0, count=0, overflow=0, and the next write restarts at elem 0, row 0.
REQ-040 SHALL cover: with LONG_OUT_EN, in_long {0xDEADBEEF, 0x1} -> m_long matches element-for-element with m_data.
